// File: rtl/spell_wb_host_pkg.sv
// Shared register map of the spell core's Wishbone slave and the host FSM state encoding.
package spell_wb_pkg;

    localparam logic [23:0] REG_PC            = 24'h000;
    localparam logic [23:0] REG_SP            = 24'h004;
    localparam logic [23:0] REG_EXEC          = 24'h008;
    localparam logic [23:0] REG_RUN           = 24'h00C;
    localparam logic [23:0] REG_CYCLES_PER_MS = 24'h010;
    localparam logic [23:0] REG_STACK_TOP     = 24'h014;
    localparam logic [23:0] REG_STACK_PUSH    = 24'h018;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BUS  = 3'd1,
        ST_GAP  = 3'd2,
        ST_POLL = 3'd3,
        ST_RESP = 3'd4
    } host_state_e;

endpackage

// File: rtl/spell_wb_host_if.sv
// Command/response port (controller is master) and Wishbone classic bus (host is master).
interface spell_wb_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_wait_sleep;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wait_sleep, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wait_sleep, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface spell_wb_bus_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_ack, i_wb_data
    );
    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_ack, i_wb_data
    );
endinterface

// File: rtl/spell_wb_host_timeout.sv
// spell_wb_timeout: saturating wait counter; expire_o fires combinationally on the increment that reaches LIMIT.
// No backpressure; clr_i has priority over inc_i.
module spell_wb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = inc_i && !clr_i && (cnt_q >= CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spell_wb_host.sv
// spell_wb_host: one command -> one single-beat Wishbone cycle, optional REG_RUN poll; response >= 2 cycles after accept,
// cmd_ready low until the response handshake. Bus timeout only when SPELL_WB_HOST_TIMEOUT_EN is defined.
module spell_wb_host
    import spell_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_POLLS      = 1023
) (
    input  logic           clk,
    input  logic           rst,
    spell_wb_host_if.slave cmd_if,
    spell_wb_bus_if.master wb_if
);
    localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);

    if (TIMEOUT_CYCLES == 0 || MAX_POLLS == 0) begin : g_bad_params
        $error("spell_wb_host: TIMEOUT_CYCLES and MAX_POLLS must be nonzero");
    end

    host_state_e       state_q, state_d;
    logic              we_q, wait_sleep_q;
    logic [23:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              accept, in_bus, in_poll, bus_active, expired;

    assign accept     = (state_q == ST_IDLE) && cmd_if.cmd_valid;
    assign in_bus     = (state_q == ST_BUS);
    assign in_poll    = (state_q == ST_POLL);
    assign bus_active = in_bus || in_poll;

`ifdef SPELL_WB_HOST_TIMEOUT_EN
    spell_wb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!bus_active),
        .inc_i    (bus_active && !wb_if.i_wb_ack),
        .expire_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Bus strobes decode straight from the async-reset state register so reset drops them immediately.
    assign cmd_if.cmd_ready = (state_q == ST_IDLE);
    assign cmd_if.rsp_valid = (state_q == ST_RESP);
    assign cmd_if.rsp_rdata = rdata_q;
    assign cmd_if.rsp_err   = err_q;
    assign wb_if.o_wb_cyc   = bus_active;
    assign wb_if.o_wb_stb   = bus_active;
    assign wb_if.o_wb_we    = in_bus && we_q;
    assign wb_if.o_wb_addr  = in_bus  ? {8'h00, addr_q}  :
                              in_poll ? {8'h00, REG_RUN} : 32'h0;
    assign wb_if.o_wb_data  = (in_bus && we_q) ? wdata_q : 32'h0;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    state_d    = ST_BUS;
                    rdata_d    = 32'h0;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                end
            end
            ST_BUS: begin
                if (wb_if.i_wb_ack) begin
                    rdata_d = we_q ? 32'h0 : wb_if.i_wb_data;
                    state_d = wait_sleep_q ? ST_GAP : ST_RESP;
                end else if (expired) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_GAP: begin
                state_d = ST_POLL;
            end
            ST_POLL: begin
                if (wb_if.i_wb_ack) begin
                    rdata_d = wb_if.i_wb_data;
                    if (poll_cnt_q != POLL_W'(MAX_POLLS)) begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                    if (!wb_if.i_wb_data[0]) begin
                        state_d = ST_RESP;
                    end else if (poll_cnt_d == POLL_W'(MAX_POLLS)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (expired) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cmd_if.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            poll_cnt_q   <= '0;
            we_q         <= 1'b0;
            wait_sleep_q <= 1'b0;
            addr_q       <= 24'h0;
            wdata_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
            if (accept) begin
                we_q         <= cmd_if.cmd_we;
                wait_sleep_q <= cmd_if.cmd_wait_sleep;
                addr_q       <= cmd_if.cmd_addr;
                wdata_q      <= cmd_if.cmd_wdata;
            end
        end
    end

endmodule

// File: doc/spell_wb_host.md
# spell_wb_host

Wishbone classic initiator that drives the register interface of the `spell` core: PC, SP, EXEC, RUN, CYCLES_PER_MS, STACK_TOP and STACK_PUSH. It accepts one command at a time over a valid/ready port and runs exactly one single-beat bus cycle per command. Optionally it polls REG_RUN until the core reaches Sleep, then returns read data or an error over a valid/ready response port. It sits between a debug or bring-up controller (UART bridge, test sequencer) and the core's Wishbone slave port.

## Interface
- TIMEOUT_CYCLES, 255: max cycles waiting for `i_wb_ack` per bus cycle (only with timeout enabled).
- MAX_POLLS, 1023: max REG_RUN reads in one poll sequence.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  host idle, command accepted when valid&&ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  24  register offset; upper 8 bits of `o_wb_addr` driven 0.
- cmd_wdata  in  32  write data.
- cmd_wait_sleep  in  1  after the access, poll REG_RUN until bit0 = 0.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data: last REG_RUN value if polled, else 0 for writes.
- rsp_err  out  1  timeout or poll limit exceeded.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone controls.
- o_wb_addr  out  32  address.
- o_wb_data  out  32  write data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_data  in  32  slave read data.

## Operation
- States: IDLE, BUS, GAP, POLL, RESP.
- IDLE: cmd_ready=1. On accept, latch we/addr/wdata/wait_sleep, clear the timeout and poll counters, go to BUS.
- BUS: cyc=stb=1, we/addr/data from latched command. On `i_wb_ack`:
  - Capture `i_wb_data` into rsp_rdata for reads; writes set rsp_rdata to 0.
  - Drop cyc/stb at the same edge.
  - If wait_sleep, go to GAP; else go to RESP.
- GAP: one cycle with cyc=stb=0, then POLL.
- POLL: read of 0x00C (same handshake as BUS). On ack:
  - Poll counter increments; rsp_rdata = `i_wb_data`.
  - If bit0 = 0, go to RESP.
  - Else if poll count == MAX_POLLS, set err and go to RESP.
  - Else go to GAP.
- RESP: rsp_valid=1 and outputs stable. When rsp_ready, go to IDLE.
- stb is never held high across two commands. At least one cycle of stb=0 separates consecutive bus cycles, because STACK_PUSH is edge-qualified at the slave.
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, o_wb_cyc/stb/we=0, o_wb_addr=0, o_wb_data=0. Counters are 0.
- Reset mid-bus-cycle: cyc/stb drop asynchronously. The in-flight command is lost and no response is produced.
- An ack arriving in IDLE, GAP or RESP is ignored.

## Timing
- Command accepted at edge N. cyc/stb are high from N+1.
- The `spell` slave acks in the cycle after it samples stb, so the earliest ack is at N+2, with stb dropped at that edge.
- Earliest rsp_valid is at cycle N+2 (registered). Minimum command-to-response latency: 2 cycles without polling.
- Each poll iteration takes 3 cycles: 1 GAP plus 2 bus cycles.
- cmd_ready is 0 from accept until the RESP handshake completes. rsp_valid&&rsp_ready and cmd_valid in the same cycle: the new command is accepted one cycle later (IDLE).
- Timeout counter width is clog2(TIMEOUT_CYCLES+1). Poll counter width is clog2(MAX_POLLS+1). Neither wraps: both saturate at the limit.

## Configuration
- SPELL_WB_HOST_TIMEOUT_EN defined:
  - In BUS/POLL, the counter increments each cycle without ack.
  - Reaching TIMEOUT_CYCLES drops cyc/stb and goes to RESP with err=1 and rdata=0.
  - An ack in the same cycle as expiry wins: normal completion.
- Undefined: no counter logic. BUS/POLL wait indefinitely for ack. rsp_err is set only by the poll limit.

## Structure
- Shared package `spell_wb_pkg`: register offsets REG_PC 0x000, REG_SP 0x004, REG_EXEC 0x008, REG_RUN 0x00C, REG_CYCLES_PER_MS 0x010, REG_STACK_TOP 0x014, REG_STACK_PUSH 0x018. Also the host state enum.
- One sub-module, `spell_wb_timeout`: saturating cycle counter with clear and expire outputs. It is instantiated only under SPELL_WB_HOST_TIMEOUT_EN.

## Test plan
- Read of REG_CYCLES_PER_MS after reset against a `spell` instance → rsp_rdata=0x00002710, err=0, rsp_valid 2 cycles after accept.
- Back-to-back writes to REG_STACK_PUSH of 0x11 then 0x22 → core SP=2, stack top 0x22. Check stb low ≥1 cycle between the two.
- Write REG_EXEC='+' with cmd_wait_sleep=1 after pushing 3 and 4 → poll ends with rsp_rdata bit0=0, then a REG_STACK_TOP read returns 0x07.
- Slave model never acks, TIMEOUT_CYCLES=8, macro defined → cyc/stb drop after 8 cycles, err=1, rdata=0. Macro undefined → cyc stays high for 100 cycles.
- Slave model keeps RUN bit0=1, MAX_POLLS=4 → exactly 4 REG_RUN reads, err=1, rsp_rdata bit0=1.
- Assert reset while stb=1 → cyc/stb low before the next clock edge, rsp_valid=0, cmd_ready=1 after release.
